irrigation_zone_scheduler: RTL

//  Multi-zone successor to the single-output irrigation gate. Services ZONES dry-earth requests one zone at
//  a time, round-robin, through a timed FSM: valve settle, watering with min/max on-time, cooldown.

---
 rtl/irrigation_pkg.sv | 19 +
 rtl/irrigation_zone_scheduler_rr_arbiter.sv | 28 ++
 rtl/irrigation_zone_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/irrigation_pkg.sv
// Shared state encoding and default timing constants for the irrigation zone scheduler.
package irrigation_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WATER,
        ST_COOLDOWN,
        ST_FAULT
    } state_t;

    localparam int unsigned DEF_ZONES    = 4;
    localparam int unsigned DEF_TIMER_W  = 8;
    localparam int unsigned DEF_SETTLE   = 2;
    localparam int unsigned DEF_MIN_ON   = 4;
    localparam int unsigned DEF_MAX_ON   = 30;
    localparam int unsigned DEF_COOLDOWN = 3;

endpackage

// File: rtl/irrigation_zone_scheduler_rr_arbiter.sv
// Round-robin search: first set request at or after the pointer, wrapping to zone 0.
module rr_arbiter #(
    parameter int unsigned ZONES = 4
) (
    input  logic [ZONES-1:0]         req,
    input  logic [$clog2(ZONES)-1:0] ptr,
    output logic [$clog2(ZONES)-1:0] idx,
    output logic                     found
);

    localparam int unsigned IDX_W = $clog2(ZONES);

    int unsigned cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < ZONES; k++) begin
            cand = (32'(ptr) + k) % ZONES;
            if (!found && req[IDX_W'(cand)]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/irrigation_zone_scheduler.sv
// Multi-zone irrigation scheduler: round-robin zone selection, settle/water/cooldown timing, interlock.
// Define IRR_FAULT_LATCH_EN to latch sensor conflicts into a sticky FAULT state released by fault_clear.
module irrigation_zone_scheduler
    import irrigation_pkg::*;
#(
    parameter int unsigned ZONES    = DEF_ZONES,
    parameter int unsigned TIMER_W  = DEF_TIMER_W,
    parameter int unsigned SETTLE   = DEF_SETTLE,
    parameter int unsigned MIN_ON   = DEF_MIN_ON,
    parameter int unsigned MAX_ON   = DEF_MAX_ON,
    parameter int unsigned COOLDOWN = DEF_COOLDOWN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tick,
    input  logic [ZONES-1:0]         zone_dry,
    input  logic                     water_sensor_conflicting,
    input  logic                     low_water_level,
    input  logic                     fault_clear,
    output logic [ZONES-1:0]         valve,
    output logic                     pump,
    output logic [$clog2(ZONES)-1:0] active_zone,
    output logic                     busy,
    output logic                     fault,
    output logic                     cycle_done
);

    localparam int unsigned IDX_W = $clog2(ZONES);
    localparam logic [TIMER_W-1:0] SETTLE_T   = TIMER_W'(SETTLE);
    localparam logic [TIMER_W-1:0] MIN_ON_T   = TIMER_W'(MIN_ON);
    localparam logic [TIMER_W-1:0] MAX_ON_T   = TIMER_W'(MAX_ON);
    localparam logic [TIMER_W-1:0] COOLDOWN_T = TIMER_W'(COOLDOWN);

    state_t             state, state_nxt;
    logic [TIMER_W-1:0] cnt, cnt_nxt, cnt_inc_c;
    logic [IDX_W-1:0]   rr_ptr, rr_nxt, zone_nxt, sel_c;
    logic               found_c, ok_c, done_nxt;
    logic [ZONES-1:0]   valve_nxt;
    logic               pump_nxt, busy_nxt, fault_nxt;

    rr_arbiter #(.ZONES(ZONES)) u_arb (
        .req   (zone_dry),
        .ptr   (rr_ptr),
        .idx   (sel_c),
        .found (found_c)
    );

    assign ok_c      = ~water_sensor_conflicting & low_water_level;
    assign cnt_inc_c = (&cnt) ? cnt : cnt + TIMER_W'(1);

    // Next-state, counter and next-output decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rr_nxt    = rr_ptr;
        zone_nxt  = active_zone;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ok_c && found_c) begin
                    state_nxt = ST_SETTLE;
                    zone_nxt  = sel_c;
                    rr_nxt    = (sel_c == IDX_W'(ZONES - 1)) ? '0 : sel_c + IDX_W'(1);
                    cnt_nxt   = '0;
                end
            end
            ST_SETTLE: begin
                if (!ok_c) begin
                    state_nxt = ST_COOLDOWN;
                    cnt_nxt   = '0;
                end else if (tick) begin
                    if (cnt_inc_c >= SETTLE_T) begin
                        state_nxt = ST_WATER;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc_c;
                    end
                end
            end
            ST_WATER: begin
                // Exit is evaluated on the current count, so a coincident tick is not counted
                if (!ok_c || (cnt >= MIN_ON_T && !zone_dry[active_zone]) || cnt == MAX_ON_T) begin
                    state_nxt = ST_COOLDOWN;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else if (tick) begin
                    cnt_nxt = cnt_inc_c;
                end
            end
            ST_COOLDOWN: begin
                if (tick) begin
                    if (cnt_inc_c >= COOLDOWN_T) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc_c;
                    end
                end
            end
`ifdef IRR_FAULT_LATCH_EN
            ST_FAULT: begin
                if (fault_clear && !water_sensor_conflicting) begin
                    state_nxt = ST_COOLDOWN;
                    cnt_nxt   = '0;
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

`ifdef IRR_FAULT_LATCH_EN
        if (water_sensor_conflicting) begin
            state_nxt = ST_FAULT;
            cnt_nxt   = '0;
            done_nxt  = (state == ST_WATER);
        end
        fault_nxt = (state_nxt == ST_FAULT);
`else
        fault_nxt = water_sensor_conflicting;
`endif

        valve_nxt = '0;
        if (state_nxt == ST_SETTLE || state_nxt == ST_WATER) begin
            valve_nxt = ZONES'(1) << zone_nxt;
        end
        pump_nxt = (state_nxt == ST_WATER);
        busy_nxt = (state_nxt != ST_IDLE) && (state_nxt != ST_FAULT);
    end

`ifndef IRR_FAULT_LATCH_EN
    logic unused_fault_clear;
    assign unused_fault_clear = fault_clear;
`endif

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rr_ptr      <= '0;
            active_zone <= '0;
            valve       <= '0;
            pump        <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
            cycle_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rr_ptr      <= rr_nxt;
            active_zone <= zone_nxt;
            valve       <= valve_nxt;
            pump        <= pump_nxt;
            busy        <= busy_nxt;
            fault       <= fault_nxt;
            cycle_done  <= done_nxt;
        end
    end

endmodule
